// File: rtl/rmem_read_responder.sv
// Memory-side responder for the coprocessor read handshake: one word read on the data bus per start pulse,
// result returned with a single-cycle done pulse. One transaction in flight at a time.
module rmem_read_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  err_reg,   err_next;
  logic [CNT_W-1:0]      cnt_reg,   cnt_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Bus events take priority over timeout expiry in the same cycle.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          addr_next  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          cnt_next   = '0;
          state_next = WAIT;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          rdata_next = mem_rdata_i;
          err_next   = mem_err_i;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rdata_o    = rdata_reg;
  assign err_o      = err_reg;
  assign done_o     = (state_reg == RESP);
  assign busy_o     = (state_reg != IDLE);
  assign mem_req_o  = (state_reg == REQ);
  assign mem_addr_o = addr_reg;
  assign mem_we_o   = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      assign mem_be_o[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_rmem_read_responder.sv
// Directed self-checking bench for rmem_read_responder with a hand-driven bus and TIMEOUT_CYCLES=8.
module tb_rmem_read_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] addr_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int done_pulses = 0;
  int req_base;
  int done_base;
  int n;

  rmem_read_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .addr_i(addr_i),
    .rdata_o(rdata_o),
    .done_o(done_o),
    .err_o(err_o),
    .busy_o(busy_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_req_o) req_cycles++;
    if (done_o) done_pulses++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  task automatic mark();
    req_base  = req_cycles;
    done_base = done_pulses;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    tick(); tick();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", err_o, 0);
    check("tie_we", mem_we_o, 0);
    check("tie_be", mem_be_o, 4'hF);
    rst_ni = 1'b1;
    tick();

    // Basic minimum-latency read
    mark();
    start_i = 1'b1; addr_i = 32'h0000_1004;
    tick();
    start_i = 1'b0;
    check("basic_busy", busy_o, 1);
    check("basic_req", mem_req_o, 1);
    check("basic_addr", mem_addr_o, 32'h0000_1004);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    check("basic_req_drop", mem_req_o, 0);
    check("basic_no_done_early", done_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    check("basic_done", done_o, 1);
    check("basic_rdata", rdata_o, 32'hDEAD_BEEF);
    check("basic_err", err_o, 0);
    tick();
    check("basic_done_1cyc", done_o, 0);
    check("basic_idle", busy_o, 0);
    check("basic_rdata_hold", rdata_o, 32'hDEAD_BEEF);

    // Wait states: gnt after 4 stall cycles, rvalid after 3 more
    mark();
    start_i = 1'b1; addr_i = 32'h0000_0040;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ws_req_held", mem_req_o, 1);
      check("ws_addr_stable", mem_addr_o, 32'h0000_0040);
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_wait_no_done", done_o, 0);
      tick();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_rvalid_i = 1'b0;
    check("ws_done", done_o, 1);
    check("ws_rdata", rdata_o, 32'hCAFE_F00D);
    tick(); tick();
    check("ws_req_cycles", req_cycles - req_base, 5);
    check("ws_done_count", done_pulses - done_base, 1);

    // Bus error response
    start_i = 1'b1; addr_i = 32'h0000_0030;
    tick();
    start_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h0000_1234;
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    check("berr_done", done_o, 1);
    check("berr_err", err_o, 1);
    check("berr_rdata", rdata_o, 32'h0000_1234);
    tick();

    // Timeout: never granted
    mark();
    start_i = 1'b1; addr_i = 32'h0000_0050;
    tick();
    start_i = 1'b0;
    check("to_err_cleared", err_o, 0);
    n = 0;
    while (!done_o && n < 50) begin
      tick();
      n++;
    end
    check("to_done", done_o, 1);
    check("to_err", err_o, 1);
    check("to_rdata", rdata_o, 0);
    check("to_req_cycles", req_cycles - req_base, 8);
    tick();
    check("to_req_low", mem_req_o, 0);
    check("to_idle", busy_o, 0);

    // Bus events win over timeout expiry in the same cycle
    mark();
    start_i = 1'b1; addr_i = 32'h0000_0060;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("edge_still_req", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    check("edge_gnt_wins", busy_o & ~done_o, 1);
    for (int i = 0; i < 7; i++) tick();
    check("edge_still_wait", done_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_55AA;
    tick();
    mem_rvalid_i = 1'b0;
    check("edge_done", done_o, 1);
    check("edge_err", err_o, 0);
    check("edge_rdata", rdata_o, 32'h0000_55AA);
    check("edge_req_cycles", req_cycles - req_base, 8);
    tick();

    // Alignment and start while busy / in RESP ignored
    mark();
    start_i = 1'b1; addr_i = 32'h0000_2003;
    tick();
    check("al_addr", mem_addr_o, 32'h0000_2000);
    addr_i = 32'h0000_4000; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
    check("al_addr_kept", mem_addr_o, 32'h0000_2000);
    tick();
    mem_rvalid_i = 1'b0;
    check("al_done", done_o, 1);
    tick();
    start_i = 1'b0;
    check("al_resp_start_ignored", busy_o, 0);
    tick(); tick();
    check("al_req_cycles", req_cycles - req_base, 1);
    check("al_done_count", done_pulses - done_base, 1);
    check("al_rdata", rdata_o, 32'h0000_0077);

    // Reset in WAIT, then a fresh transaction
    mark();
    start_i = 1'b1; addr_i = 32'h0000_0100;
    tick();
    start_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst_ni = 1'b0;
    tick();
    check("mr_busy", busy_o, 0);
    check("mr_done", done_o, 0);
    check("mr_rdata", rdata_o, 0);
    check("mr_err", err_o, 0);
    check("mr_addr", mem_addr_o, 0);
    check("mr_req", mem_req_o, 0);
    rst_ni = 1'b1;
    tick(); tick();
    check("mr_no_done", done_pulses - done_base, 0);
    start_i = 1'b1; addr_i = 32'h0000_0104;
    tick();
    start_i = 1'b0; mem_gnt_i = 1'b1;
    check("mr2_addr", mem_addr_o, 32'h0000_0104);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_0001;
    tick();
    mem_rvalid_i = 1'b0;
    check("mr2_done", done_o, 1);
    check("mr2_rdata", rdata_o, 32'hA5A5_0001);
    check("mr2_err", err_o, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
